// File: rtl/approx_max_stream.sv
// approx_max_stream: framed streaming max/argmax tracker with a per-frame
// selectable exact or approximate (DROP LSBs ignored) comparison.
module approx_max_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 8,
  parameter int unsigned DROP  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             approx_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_ovf,
  output logic             out_mode
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] best, best_n;
  logic [IDX_W-1:0] best_idx, best_idx_n;
  logic [IDX_W:0]   pos, pos_n;
  logic             mode_r, mode_n;
  logic             ovf_r, ovf_n;
  logic             out_valid_n, out_ovf_n, out_mode_n;
  logic [WIDTH-1:0] out_max_n;
  logic [IDX_W-1:0] out_idx_n;
  logic             accept;

  // Comparison key: approximate mode discards the DROP least significant bits.
  function automatic logic [WIDTH-1:0] key(input logic m, input logic [WIDTH-1:0] x);
    return m ? (x >> DROP) : x;
  endfunction

  assign in_ready = (state != HOLD);
  assign accept   = in_valid && in_ready;

  // Next-state and next-value logic for the tracker and the result registers.
  always_comb begin
    state_n     = state;
    best_n      = best;
    best_idx_n  = best_idx;
    pos_n       = pos;
    mode_n      = mode_r;
    ovf_n       = ovf_r;
    out_valid_n = out_valid;
    out_max_n   = out_max;
    out_idx_n   = out_idx;
    out_ovf_n   = out_ovf;
    out_mode_n  = out_mode;
    case (state)
      IDLE: begin
        if (accept) begin
          best_n     = in_data;
          best_idx_n = '0;
          pos_n      = (IDX_W+1)'(1);
          mode_n     = approx_en;
          ovf_n      = 1'b0;
          state_n    = in_last ? HOLD : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          // pos MSB set means the position has saturated past the last indexable slot.
          if (!pos[IDX_W]) begin
            if (key(mode_r, in_data) > key(mode_r, best)) begin
              best_n     = in_data;
              best_idx_n = pos[IDX_W-1:0];
            end
            pos_n = pos + 1'b1;
          end else begin
            ovf_n = 1'b1;
          end
          if (in_last) state_n = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // The final beat is folded into best before the result is captured.
    if (accept && in_last) begin
      out_valid_n = 1'b1;
      out_max_n   = best_n;
      out_idx_n   = best_idx_n;
      out_ovf_n   = ovf_n;
      out_mode_n  = mode_n;
    end
  end

  // State, tracker and result registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      best      <= '0;
      best_idx  <= '0;
      pos       <= '0;
      mode_r    <= 1'b0;
      ovf_r     <= 1'b0;
      out_valid <= 1'b0;
      out_max   <= '0;
      out_idx   <= '0;
      out_ovf   <= 1'b0;
      out_mode  <= 1'b0;
    end else begin
      state     <= state_n;
      best      <= best_n;
      best_idx  <= best_idx_n;
      pos       <= pos_n;
      mode_r    <= mode_n;
      ovf_r     <= ovf_n;
      out_valid <= out_valid_n;
      out_max   <= out_max_n;
      out_idx   <= out_idx_n;
      out_ovf   <= out_ovf_n;
      out_mode  <= out_mode_n;
    end
  end

endmodule

// File: tb/tb_approx_max_stream.sv
// Bench for approx_max_stream with a small index width so overflow is reachable.
module tb_approx_max_stream;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned DROP  = 2;
  localparam int unsigned MAXP  = (1 << IDX_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             approx_en = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_max;
  logic [IDX_W-1:0] out_idx;
  logic             out_ovf;
  logic             out_mode;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] frame_q[$];
  logic             mode_q[$];

  approx_max_stream #(.WIDTH(WIDTH), .IDX_W(IDX_W), .DROP(DROP)) dut (
    .clk(clk), .rst_n(rst_n), .approx_en(approx_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
    .out_idx(out_idx), .out_ovf(out_ovf), .out_mode(out_mode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: first sample seeds, later eligible samples win only on a strictly larger key.
  task automatic model(output logic [WIDTH-1:0] emax, output int unsigned eidx,
                       output logic eovf, output logic emode);
    int unsigned kb, kc;
    emode = mode_q[0];
    emax  = frame_q[0];
    eidx  = 0;
    for (int i = 1; i < frame_q.size(); i++) begin
      kb = emode ? int'(emax) / (1 << DROP) : int'(emax);
      kc = emode ? int'(frame_q[i]) / (1 << DROP) : int'(frame_q[i]);
      if (i <= MAXP && kc > kb) begin
        emax = frame_q[i];
        eidx = i;
      end
    end
    eovf = (frame_q.size() > MAXP + 1);
  endtask

  // Present one beat (called #1 after a rising edge) and wait until it is taken.
  task automatic beat(input logic [WIDTH-1:0] d, input logic last, input logic am);
    int unsigned n = 0;
    in_valid = 1'b1; in_data = d; in_last = last; approx_en = am;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) chk("beat_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = WIDTH'($urandom); in_last = 1'($urandom);
    approx_en = 1'($urandom);
  endtask

  task automatic run_frame(input logic [WIDTH-1:0] emax, input int unsigned eidx,
                           input logic eovf, input logic emode,
                           input int unsigned bp, input bit gaps);
    for (int i = 0; i < frame_q.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0; in_data = WIDTH'($urandom); in_last = 1'($urandom);
        @(posedge clk); #1;
      end
      beat(frame_q[i], (i == frame_q.size() - 1), mode_q[i]);
    end
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_max", 32'(out_max), 32'(emax));
    chk("out_idx", 32'(out_idx), eidx);
    chk("out_ovf", 32'(out_ovf), 32'(eovf));
    chk("out_mode", 32'(out_mode), 32'(emode));
    out_ready = 1'b0;
    for (int c = 0; c < bp; c++) begin
      @(posedge clk); #1;
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_max", 32'(out_max), 32'(emax));
      chk("hold_idx", 32'(out_idx), eidx);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("xfer_valid", 32'(out_valid), 32'd0);
    chk("xfer_in_ready", 32'(in_ready), 32'd1);
    chk("xfer_max_held", 32'(out_max), 32'(emax));
  endtask

  task automatic set_frame(input int n, input logic [WIDTH-1:0] d0, input logic [WIDTH-1:0] d1,
                           input logic [WIDTH-1:0] d2, input logic [WIDTH-1:0] d3,
                           input logic [WIDTH-1:0] d4, input logic m0, input logic mr);
    logic [WIDTH-1:0] d[5];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3; d[4] = d4;
    frame_q.delete(); mode_q.delete();
    for (int i = 0; i < n; i++) begin
      frame_q.push_back(d[i]);
      mode_q.push_back(i == 0 ? m0 : mr);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] emax;
    int unsigned      eidx;
    logic             eovf, emode;
    int               n;

    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_max", 32'(out_max), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    chk("rst_mode", 32'(out_mode), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Exact mode, tie keeps the earlier sample.
    set_frame(4, 8'd10, 8'd50, 8'd50, 8'd30, 8'd0, 1'b0, 1'b0);
    run_frame(8'd50, 1, 1'b0, 1'b0, 0, 0);
    // Approximate: all keys equal, first wins.
    set_frame(3, 8'h41, 8'h42, 8'h40, 8'h0, 8'h0, 1'b1, 1'b1);
    run_frame(8'h41, 0, 1'b0, 1'b1, 0, 0);
    set_frame(3, 8'h41, 8'h42, 8'h40, 8'h0, 8'h0, 1'b0, 1'b0);
    run_frame(8'h42, 1, 1'b0, 1'b0, 0, 0);
    // Mode latched on the first beat.
    set_frame(2, 8'h41, 8'h42, 8'h0, 8'h0, 8'h0, 1'b1, 1'b0);
    run_frame(8'h41, 0, 1'b0, 1'b1, 0, 0);
    // Single-beat frame under backpressure.
    set_frame(1, 8'hC8, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0);
    run_frame(8'hC8, 0, 1'b0, 1'b0, 3, 0);
    // Overflow: position 4 is beyond the index range and cannot win.
    set_frame(5, 8'd5, 8'd100, 8'd7, 8'd9, 8'd200, 1'b0, 1'b0);
    run_frame(8'd100, 1, 1'b1, 1'b0, 0, 0);

    // Asynchronous reset mid-frame discards the partial frame.
    beat(8'd90, 1'b0, 1'b0);
    beat(8'd120, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_max", 32'(out_max), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_valid2", 32'(out_valid), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    set_frame(1, 8'd40, 8'h0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0);
    run_frame(8'd40, 0, 1'b0, 1'b0, 0, 0);

    // Randomized frames against the reference model.
    for (int f = 0; f < 60; f++) begin
      n = $urandom_range(1, 8);
      frame_q.delete(); mode_q.delete();
      for (int i = 0; i < n; i++) begin
        frame_q.push_back(($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 7) + 8'h40)
                                                      : WIDTH'($urandom));
        mode_q.push_back(1'($urandom));
      end
      model(emax, eidx, eovf, emode);
      run_frame(emax, eidx, eovf, emode, $urandom_range(0, 3), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
